// File: rtl/mandel_pkg.sv
// Shared widths, FSM state type and colour thresholds for the mandelbrot pixel scheduler.
package mandel_pkg;

  localparam int unsigned FIX_W  = 27;
  localparam int unsigned FRAC_W = 23;
  localparam int unsigned ITER_W = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_WRITE,
    S_ADVANCE,
    S_FINISH
  } state_e;

  localparam logic [ITER_W-1:0] THR_RED    = 32'd256;
  localparam logic [ITER_W-1:0] THR_YELLOW = 32'd64;
  localparam logic [ITER_W-1:0] THR_GREEN  = 32'd16;
  localparam logic [ITER_W-1:0] THR_BLUE   = 32'd4;

  localparam logic [7:0] COL_INSIDE = 8'h00;
  localparam logic [7:0] COL_RED    = 8'hE0;
  localparam logic [7:0] COL_YELLOW = 8'hFC;
  localparam logic [7:0] COL_GREEN  = 8'h1C;
  localparam logic [7:0] COL_BLUE   = 8'h03;
  localparam logic [7:0] COL_DARK   = 8'h01;

endpackage

// File: rtl/mandel_color_map.sv
// Combinational escape-count to RGB332 colour map; the caller registers the result.
module mandel_color_map
  import mandel_pkg::*;
(
  input  logic [ITER_W-1:0] n_i,
  input  logic [ITER_W-1:0] max_iter_i,
  output logic [7:0]        color_o
);

  always_comb begin
    if (n_i >= max_iter_i)      color_o = COL_INSIDE;
    else if (n_i >= THR_RED)    color_o = COL_RED;
    else if (n_i >= THR_YELLOW) color_o = COL_YELLOW;
    else if (n_i >= THR_GREEN)  color_o = COL_GREEN;
    else if (n_i >= THR_BLUE)   color_o = COL_BLUE;
    else                        color_o = COL_DARK;
  end

endmodule

// File: rtl/mandelbrot_pixel_scheduler.sv
// Row-major frame scanner driving one mandelbrot_iterator and writing RGB332 pixels.
// Optional per-frame busy-cycle counter enabled by defining MANDEL_FRAME_TIMER_EN.
module mandelbrot_pixel_scheduler
  import mandel_pkg::*;
#(
  parameter int unsigned WIDTH  = 640,
  parameter int unsigned HEIGHT = 480,
  parameter int unsigned AW     = 19
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [FIX_W-1:0]  cr_start,
  input  logic [FIX_W-1:0]  ci_start,
  input  logic [FIX_W-1:0]  dx,
  input  logic [FIX_W-1:0]  dy,
  input  logic [ITER_W-1:0] max_iter,
  output logic [FIX_W-1:0]  iter_cr,
  output logic [FIX_W-1:0]  iter_ci,
  output logic [ITER_W-1:0] iter_max,
  output logic              iter_reset,
  input  logic [ITER_W-1:0] iter_num,
  input  logic              iter_done,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [AW-1:0]     wr_addr,
  output logic [7:0]        wr_color,
  output logic              busy,
  output logic              frame_done
`ifdef MANDEL_FRAME_TIMER_EN
  ,
  output logic [31:0]       frame_cycles
`endif
);

  localparam int unsigned XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int unsigned YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

  state_e            state_q, state_d;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [FIX_W-1:0]  cr_q, cr_d, ci_q, ci_d;
  logic [FIX_W-1:0]  cr0_q, cr0_d, dx_q, dx_d, dy_q, dy_d;
  logic [ITER_W-1:0] max_q, max_d;
  logic [7:0]        color_q, color_d, color_map;
  logic              last_pix;

  assign last_pix = (x_q == X_LAST) && (y_q == Y_LAST);

  mandel_color_map u_color_map (
    .n_i        (iter_num),
    .max_iter_i (max_q),
    .color_o    (color_map)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start) state_d = S_LAUNCH;
      S_LAUNCH:  state_d = S_WAIT;
      S_WAIT:    if (iter_done) state_d = S_WRITE;
      S_WRITE:   if (wr_ready) state_d = last_pix ? S_FINISH : S_ADVANCE;
      S_ADVANCE: state_d = S_LAUNCH;
      S_FINISH:  state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    iter_reset = 1'b1;
    wr_valid   = 1'b0;
    busy       = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      S_LAUNCH:  busy = 1'b1;
      S_WAIT:    begin iter_reset = 1'b0; busy = 1'b1; end
      S_WRITE:   begin iter_reset = 1'b0; busy = 1'b1; wr_valid = 1'b1; end
      S_ADVANCE: begin iter_reset = 1'b0; busy = 1'b1; end
      S_FINISH:  frame_done = 1'b1;
      default:   ;
    endcase
  end

  // Coordinates step incrementally; cr0 restores the row origin on wrap.
  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    addr_d  = addr_q;
    cr_d    = cr_q;
    ci_d    = ci_q;
    cr0_d   = cr0_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    max_d   = max_q;
    color_d = color_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          x_d    = '0;
          y_d    = '0;
          addr_d = '0;
          cr_d   = cr_start;
          ci_d   = ci_start;
          cr0_d  = cr_start;
          dx_d   = dx;
          dy_d   = dy;
          max_d  = max_iter;
        end
      end
      S_WAIT: if (iter_done) color_d = color_map;
      S_ADVANCE: begin
        addr_d = addr_q + AW'(1);
        if (x_q != X_LAST) begin
          x_d  = x_q + XW'(1);
          cr_d = cr_q + dx_q;
        end else begin
          x_d  = '0;
          y_d  = y_q + YW'(1);
          cr_d = cr0_q;
          ci_d = ci_q - dy_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q     <= '0;
      y_q     <= '0;
      addr_q  <= '0;
      cr_q    <= '0;
      ci_q    <= '0;
      cr0_q   <= '0;
      dx_q    <= '0;
      dy_q    <= '0;
      max_q   <= '0;
      color_q <= '0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      addr_q  <= addr_d;
      cr_q    <= cr_d;
      ci_q    <= ci_d;
      cr0_q   <= cr0_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      max_q   <= max_d;
      color_q <= color_d;
    end
  end

  assign iter_cr  = cr_q;
  assign iter_ci  = ci_q;
  assign iter_max = max_q;
  assign wr_addr  = addr_q;
  assign wr_color = color_q;

`ifdef MANDEL_FRAME_TIMER_EN
  logic [31:0] fc_q, fc_d;

  always_comb begin
    fc_d = fc_q;
    if (state_q == S_IDLE && start) fc_d = '0;
    else if (busy && fc_q != '1)    fc_d = fc_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) fc_q <= '0;
    else          fc_q <= fc_d;
  end

  assign frame_cycles = fc_q;
`endif

endmodule
